// File: rtl/uart_word_serializer_if.sv
// ============================================================================
// Module      : uart_word_serializer_if
// Description : Word-in / byte-out handshake bundle for the UART word serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_word_serializer_if #(
    parameter int WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] data_in;
    logic                    data_ready;
    logic                    ready;
    logic                    busy;
    logic                    overflow;
    logic [7:0]              tx_data;
    logic                    tx_write;
    logic                    tx_full;

    // master is the surrounding system: word producer plus the TX byte FIFO
    modport master (
        output data_in, data_ready, tx_full,
        input  ready, busy, overflow, tx_data, tx_write
    );

    modport slave (
        input  data_in, data_ready, tx_full,
        output ready, busy, overflow, tx_data, tx_write
    );
endinterface

`default_nettype wire

// File: rtl/uart_word_serializer.sv
// ============================================================================
// Module      : uart_word_serializer
// Description : Queued word-to-byte serializer with optional header/XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_serializer #(
    parameter int         WORD_BYTES  = 4,
    parameter int         FIFO_DEPTH  = 4,
    parameter bit         MSB_FIRST   = 1'b0,
    parameter bit         HEADER_EN   = 1'b0,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter bit         CHECKSUM_EN = 1'b0
) (
    input wire                    clk,
    input wire                    reset,
    uart_word_serializer_if.slave bus
);

    localparam int c_DW = 8 * WORD_BYTES;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_IW = $clog2(WORD_BYTES + 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR  = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_GAP  = 3'd4;

    logic [c_DW-1:0] mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_CW-1:0] count_q, count_d;
    logic            ready_q, overflow_q;

    logic [2:0]      state_q, state_d;
    logic [c_DW-1:0] shift_q, shift_d;
    logic [c_IW-1:0] idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic            csum_sent_q, csum_sent_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_write_q, tx_write_d;

    logic            w_push, w_pop, w_rejected, w_send;
    logic [7:0]      w_byte;

    // A full queue rejects a strobe even when a pop frees a slot on the same edge
    assign w_push     = bus.data_ready & ready_q;
    assign w_rejected = bus.data_ready & ~ready_q;
    assign w_pop      = (state_q == c_IDLE) && (count_q != '0);
    assign w_send     = ((state_q == c_HDR) || (state_q == c_DATA) || (state_q == c_CSUM))
                        && !bus.tx_full;
    assign w_byte     = MSB_FIRST ? shift_q[c_DW-1 -: 8] : shift_q[7:0];

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_CW'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_AW'(1);
            end
            count_q    <= count_d;
            ready_q    <= (count_d < c_CW'(FIFO_DEPTH));
            overflow_q <= overflow_q | w_rejected;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
            tx_data_q   <= '0;
            tx_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
            tx_data_q   <= tx_data_d;
            tx_write_q  <= tx_write_d;
        end
    end

    // GAP always follows a byte so tx_full from the FIFO has a cycle to settle
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (count_q != '0) begin
                    state_d = HEADER_EN ? c_HDR : c_DATA;
                end
            end
            c_HDR, c_DATA, c_CSUM: begin
                if (!bus.tx_full) begin
                    state_d = c_GAP;
                end
            end
            c_GAP: begin
                if (idx_q < c_IW'(WORD_BYTES)) begin
                    state_d = c_DATA;
                end else if (CHECKSUM_EN && !csum_sent_q) begin
                    state_d = c_CSUM;
                end else begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        shift_d     = shift_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
        tx_data_d   = tx_data_q;
        tx_write_d  = 1'b0;
        if (w_pop) begin
            shift_d     = mem_q[rd_ptr_q];
            idx_d       = '0;
            csum_d      = '0;
            csum_sent_d = 1'b0;
        end
        if (w_send) begin
            tx_write_d = 1'b1;
            case (state_q)
                c_HDR: begin
                    tx_data_d = HEADER_BYTE;
                end
                c_DATA: begin
                    tx_data_d = w_byte;
                    csum_d    = csum_q ^ w_byte;
                    idx_d     = idx_q + c_IW'(1);
                    shift_d   = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
                end
                default: begin
                    tx_data_d   = csum_q;
                    csum_sent_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = (count_q != '0) || (state_q != c_IDLE);
    assign bus.overflow = overflow_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_write = tx_write_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_serializer.sv
// ============================================================================
// Module      : tb_uart_word_serializer
// Description : Self-checking bench for three serializer configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_word_serializer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // a: defaults, b: MSB first + header + checksum, c: single-byte words
    uart_word_serializer_if #(.WORD_BYTES(4)) ifa ();
    uart_word_serializer_if #(.WORD_BYTES(4)) ifb ();
    uart_word_serializer_if #(.WORD_BYTES(1)) ifc ();

    uart_word_serializer #(.WORD_BYTES(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    uart_word_serializer #(.WORD_BYTES(4), .MSB_FIRST(1'b1), .HEADER_EN(1'b1),
                           .HEADER_BYTE(8'hA5), .CHECKSUM_EN(1'b1))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    uart_word_serializer #(.WORD_BYTES(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    int checks   = 0;
    int failures = 0;
    int b2b_viol  = 0;
    int full_viol = 0;

    logic [7:0] got_a[$], got_b[$], got_c[$];
    logic [7:0] exp_a[$], exp_b[$], exp_c[$];
    logic wp_a = 1'b0, wp_b = 1'b0, wp_c = 1'b0;
    logic fe_a = 1'b0, fe_b = 1'b0, fe_c = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_a;
        logic [47:0] exp_b;
    } vec_t;
    vec_t tbl[6];

    always @(posedge clk) begin
        fe_a <= ifa.tx_full;
        fe_b <= ifb.tx_full;
        fe_c <= ifc.tx_full;
    end

    always @(negedge clk) begin
        if (ifa.tx_write) got_a.push_back(ifa.tx_data);
        if (ifb.tx_write) got_b.push_back(ifb.tx_data);
        if (ifc.tx_write) got_c.push_back(ifc.tx_data);
        if ((ifa.tx_write && wp_a) || (ifb.tx_write && wp_b) || (ifc.tx_write && wp_c))
            b2b_viol <= b2b_viol + 1;
        if ((ifa.tx_write && fe_a) || (ifb.tx_write && fe_b) || (ifc.tx_write && fe_c))
            full_viol <= full_viol + 1;
        wp_a <= ifa.tx_write;
        wp_b <= ifb.tx_write;
        wp_c <= ifc.tx_write;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int which, input logic [7:0] b);
        case (which)
            0:       exp_a.push_back(b);
            1:       exp_b.push_back(b);
            default: exp_c.push_back(b);
        endcase
    endtask

    // Reference: bytes a word should produce, from the configuration rules alone
    task automatic model_push(input int which, input logic [63:0] w);
        int         wb;
        bit         msb, hdr, cs;
        logic [7:0] x, b;
        case (which)
            0:       begin wb = 4; msb = 0; hdr = 0; cs = 0; end
            1:       begin wb = 4; msb = 1; hdr = 1; cs = 1; end
            default: begin wb = 1; msb = 0; hdr = 0; cs = 0; end
        endcase
        x = 8'h00;
        if (hdr) push_exp(which, 8'hA5);
        for (int i = 0; i < wb; i++) begin
            b = 8'((w >> (8 * (msb ? (wb - 1 - i) : i))) & 64'hFF);
            x = x ^ b;
            push_exp(which, b);
        end
        if (cs) push_exp(which, x);
    endtask

    task automatic check_q(input string name, input int which);
        logic [7:0] g[$];
        logic [7:0] e[$];
        case (which)
            0:       begin g = got_a; e = exp_a; got_a.delete(); exp_a.delete(); end
            1:       begin g = got_b; e = exp_b; got_b.delete(); exp_b.delete(); end
            default: begin g = got_c; e = exp_c; got_c.delete(); exp_c.delete(); end
        endcase
        check({name, "_len"}, 64'(g.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check($sformatf("%s_byte%0d", name, i), 64'(g[i]), 64'(e[i]));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        cyc();
        while ((ifa.busy || ifb.busy || ifc.busy) && n < 400) begin
            cyc();
            n++;
        end
        check({name, "_idle"}, 64'(n < 400), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  pat;
        logic        rdy_all;
        logic [63:0] wa, wb;
        int          n, n_acc, wr_during;
        bit          dropped, exp_ovf_a, exp_ovf_b;
        logic [31:0] w;

        tbl[0] = '{32'h44332211, 32'h11223344, 48'hA5_44_33_22_11_44};
        tbl[1] = '{32'hDDCCBBAA, 32'hAABBCCDD, 48'hA5_DD_CC_BB_AA_00};
        tbl[2] = '{32'h00000000, 32'h00000000, 48'hA5_00_00_00_00_00};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 48'hA5_FF_FF_FF_FF_00};
        tbl[4] = '{32'h12345678, 32'h78563412, 48'hA5_12_34_56_78_08};
        tbl[5] = '{32'h80000001, 32'h01000080, 48'hA5_80_00_00_01_81};

        ifa.data_in = '0; ifa.data_ready = 1'b0; ifa.tx_full = 1'b0;
        ifb.data_in = '0; ifb.data_ready = 1'b0; ifb.tx_full = 1'b0;
        ifc.data_in = '0; ifc.data_ready = 1'b0; ifc.tx_full = 1'b0;
        reset = 1'b1;
        repeat (3) cyc();
        check("rst_ready_a", 64'(ifa.ready), 64'd1);
        check("rst_busy_a", 64'(ifa.busy), 64'd0);
        check("rst_ovf_a", 64'(ifa.overflow), 64'd0);
        check("rst_txw_a", 64'(ifa.tx_write), 64'd0);
        check("rst_txd_a", 64'(ifa.tx_data), 64'd0);
        check("rst_busy_b", 64'(ifb.busy), 64'd0);
        check("rst_ready_c", 64'(ifc.ready), 64'd1);
        reset = 1'b0;
        cyc();

        // First byte three cycles after acceptance, then one byte every other cycle
        ifa.data_in = 32'h44332211; ifa.data_ready = 1'b1;
        cyc();
        pat = '0; rdy_all = 1'b1;
        for (int k = 0; k < 10; k++) begin
            pat[k] = ifa.tx_write;
            rdy_all &= ifa.ready;
            ifa.data_ready = 1'b0;
            cyc();
        end
        check("latency_pattern", 64'(pat), 64'h154);
        check("latency_ready_held", 64'(rdy_all), 64'd1);
        model_push(0, 64'h44332211);
        wait_idle("latency");
        check_q("latency_bytes", 0);

        for (int i = 0; i < 6; i++) begin
            ifa.data_in = tbl[i].word; ifa.data_ready = 1'b1;
            ifb.data_in = tbl[i].word; ifb.data_ready = 1'b1;
            cyc();
            ifa.data_ready = 1'b0; ifb.data_ready = 1'b0;
            for (int k = 0; k < 4; k++) exp_a.push_back(tbl[i].exp_a[31-8*k -: 8]);
            for (int k = 0; k < 6; k++) exp_b.push_back(tbl[i].exp_b[47-8*k -: 8]);
            wait_idle($sformatf("tbl%0d", i));
            check_q($sformatf("tbl%0d_a", i), 0);
            check_q($sformatf("tbl%0d_b", i), 1);
        end

        // Stall for 10 cycles right after the first byte
        ifa.data_in = 32'hDDCCBBAA; ifa.data_ready = 1'b1;
        cyc();
        ifa.data_ready = 1'b0;
        n = 0;
        while (got_a.size() == 0 && n < 20) begin cyc(); n++; end
        check("stall_first_byte", 64'(got_a.size()), 64'd1);
        ifa.tx_full = 1'b1;
        wr_during = 0;
        repeat (10) begin cyc(); wr_during += int'(ifa.tx_write); end
        check("stall_no_write", 64'(wr_during), 64'd0);
        check("stall_count", 64'(got_a.size()), 64'd1);
        ifa.tx_full = 1'b0;
        model_push(0, 64'hDDCCBBAA);
        wait_idle("stall");
        check_q("stall_bytes", 0);

        // Fill queue with the output blocked; one word drains into the shifter
        ifa.tx_full = 1'b1;
        n_acc = 0; dropped = 1'b0;
        for (int i = 0; i < 12 && !dropped; i++) begin
            w = 32'h01010101 * (i + 1);
            ifa.data_in = w; ifa.data_ready = 1'b1;
            if (ifa.ready) begin model_push(0, 64'(w)); n_acc++; end
            else dropped = 1'b1;
            cyc();
        end
        ifa.data_ready = 1'b0;
        cyc();
        check("ovf_accepted", 64'(n_acc), 64'd5);
        check("ovf_flag", 64'(ifa.overflow), 64'd1);
        check("ovf_ready_low", 64'(ifa.ready), 64'd0);
        ifa.tx_full = 1'b0;
        wait_idle("ovf");
        check_q("ovf_bytes", 0);
        check("ovf_sticky", 64'(ifa.overflow), 64'd1);

        // Reset in the middle of a word with two more queued
        for (int i = 0; i < 3; i++) begin
            ifa.data_in = 32'hA1B2C3D4 + 32'(i); ifa.data_ready = 1'b1;
            cyc();
        end
        ifa.data_ready = 1'b0;
        n = 0;
        while (got_a.size() == 0 && n < 20) begin cyc(); n++; end
        check("rst_mid_first_byte", 64'(got_a.size()), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_mid_txw", 64'(ifa.tx_write), 64'd0);
        check("rst_mid_ready", 64'(ifa.ready), 64'd1);
        check("rst_mid_busy", 64'(ifa.busy), 64'd0);
        check("rst_mid_ovf", 64'(ifa.overflow), 64'd0);
        repeat (20) cyc();
        check("rst_mid_no_more", 64'(got_a.size()), 64'd1);
        got_a.delete();

        // Back-to-back single-byte words
        for (int v = 1; v <= 3; v++) begin
            ifc.data_in = 8'(v); ifc.data_ready = 1'b1;
            model_push(2, 64'(v));
            cyc();
        end
        ifc.data_ready = 1'b0;
        check("wb1_busy", 64'(ifc.busy), 64'd1);
        wait_idle("wb1");
        check_q("wb1_bytes", 2);

        // Randomized traffic with random back-pressure on configurations a and b
        exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
        for (int n2 = 0; n2 < 600; n2++) begin
            ifa.tx_full = ($urandom_range(0, 3) == 0);
            ifb.tx_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                wa = {$urandom, $urandom};
                ifa.data_in = wa[31:0]; ifa.data_ready = 1'b1;
                if (ifa.ready) model_push(0, 64'(wa[31:0])); else exp_ovf_a = 1'b1;
            end else ifa.data_ready = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                wb = {$urandom, $urandom};
                ifb.data_in = wb[31:0]; ifb.data_ready = 1'b1;
                if (ifb.ready) model_push(1, 64'(wb[31:0])); else exp_ovf_b = 1'b1;
            end else ifb.data_ready = 1'b0;
            cyc();
        end
        ifa.data_ready = 1'b0; ifb.data_ready = 1'b0;
        ifa.tx_full = 1'b0; ifb.tx_full = 1'b0;
        wait_idle("rand");
        check_q("rand_a", 0);
        check_q("rand_b", 1);
        check("rand_ovf_a", 64'(ifa.overflow), 64'(exp_ovf_a));
        check("rand_ovf_b", 64'(ifb.overflow), 64'(exp_ovf_b));

        cyc();
        check("no_back_to_back_writes", 64'(b2b_viol), 64'd0);
        check("no_write_while_full", 64'(full_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
